// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common-data-bus arbiter.
//   e_functional_unit : tag of a result producer; source i of the arbiter is e_functional_unit'(i)
//   cdb_msg_t         : one broadcast beat (valid, value, producing unit)
//   CDB_NUM_SRC       : number of result sources feeding the bus
//   rr_next()         : round-robin pointer successor with wrap
package cdb_arbiter_pkg;

  localparam int unsigned CDB_NUM_SRC    = 6;
  localparam int unsigned CDB_DATA_WIDTH = 64;

  typedef enum logic [2:0] {
    FuAlu0   = 3'd0,
    FuAlu1   = 3'd1,
    FuBranch = 3'd2,
    FuMul    = 3'd3,
    FuDiv    = 3'd4,
    FuLsu    = 3'd5
  } e_functional_unit;

  typedef struct packed {
    logic                      valid;
    logic [CDB_DATA_WIDTH-1:0] value;
    e_functional_unit          rs;
  } cdb_msg_t;

  // Pointer moves to the source just after the winner, wrapping n-1 -> 0.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin pick among N requesters. Holds no state.
//   req_i       : request vector
//   ptr_i       : index where the search starts (wraps N-1 -> 0)
//   grant_o     : one-hot grant, all zero when nobody requests
//   grant_idx_o : binary index of the grant (0 when none)
//   any_o       : a grant was issued
module cdb_arbiter_rr_arbiter #(
  parameter int unsigned N    = 6,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] grant_idx_o,
  output logic            any_o
);

  int unsigned cand;
  logic        found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = IdxW'(cand);
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one-entry holding slot per result source, round-robin pick,
// one registered broadcast per cycle to the register file and reservation stations.
// Optional feature macro: CDB_ARB_BYPASS_EN -- empty slots with a valid request also compete,
// and a winning request is broadcast on its accepting edge without being stored.
//   clk, rst_n    : clock (rising edge), async active-low reset
//   res_valid_i   : source i presents a result
//   res_value_i   : result data per source
//   res_ready_o   : slot i can accept (transfer on valid && ready at posedge)
//   bcast_valid_o : registered broadcast strobe, one pulse per result
//   bcast_value_o : registered broadcast value (holds when idle)
//   bcast_rs_o    : registered tag of the producing source (holds when idle)
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CDB_DATA_WIDTH,
  parameter int unsigned NUM_SRC    = CDB_NUM_SRC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    res_valid_i,
  input  logic [DATA_WIDTH-1:0] res_value_i [NUM_SRC],
  output logic [NUM_SRC-1:0]    res_ready_o,
  output logic                  bcast_valid_o,
  output logic [DATA_WIDTH-1:0] bcast_value_o,
  output e_functional_unit      bcast_rs_o
);

  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned FuW  = $bits(e_functional_unit);

  logic [NUM_SRC-1:0]    full_q, full_d;
  logic [DATA_WIDTH-1:0] slot_q [NUM_SRC];
  logic [IdxW-1:0]       ptr_q, ptr_d;

  logic                  bcast_valid_q;
  logic [DATA_WIDTH-1:0] bcast_value_q;
  e_functional_unit      bcast_rs_q;

  logic [NUM_SRC-1:0]    req;
  logic [NUM_SRC-1:0]    grant;
  logic [NUM_SRC-1:0]    fill;
  logic [IdxW-1:0]       grant_idx;
  logic                  any_grant;
  logic [DATA_WIDTH-1:0] win_value;

  // A slot being drained this cycle can take a new result on the same edge.
  assign res_ready_o = ~full_q | grant;

`ifdef CDB_ARB_BYPASS_EN
  logic [NUM_SRC-1:0] bypass;

  assign req    = full_q | res_valid_i;
  // Grant to an empty slot means the live request goes straight to the bus.
  assign bypass = grant & ~full_q;
  assign fill   = res_valid_i & res_ready_o & ~bypass;

  always_comb begin
    win_value = slot_q[grant_idx];
    if (!full_q[grant_idx]) begin
      win_value = res_value_i[grant_idx];
    end
  end
`else
  assign req  = full_q;
  assign fill = res_valid_i & res_ready_o;

  always_comb begin
    win_value = slot_q[grant_idx];
  end
`endif

  cdb_arbiter_rr_arbiter #(
    .N    (NUM_SRC),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (any_grant)
  );

  always_comb begin
    full_d = (full_q & ~grant) | fill;
    ptr_d  = ptr_q;
    if (any_grant) begin
      ptr_d = IdxW'(rr_next(32'(grant_idx), NUM_SRC));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q        <= '0;
      ptr_q         <= '0;
      bcast_valid_q <= 1'b0;
      bcast_value_q <= '0;
      bcast_rs_q    <= e_functional_unit'(FuW'(0));
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      full_q        <= full_d;
      ptr_q         <= ptr_d;
      bcast_valid_q <= any_grant;
      if (any_grant) begin
        bcast_value_q <= win_value;
        bcast_rs_q    <= e_functional_unit'(FuW'(grant_idx));
      end
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (fill[i]) begin
          slot_q[i] <= res_value_i[i];
        end
      end
    end
  end

  assign bcast_valid_o = bcast_valid_q;
  assign bcast_value_o = bcast_value_q;
  assign bcast_rs_o    = bcast_rs_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [5:0]       res_valid;
  logic [63:0]      res_value [6];
  logic [5:0]       res_ready;
  logic             bcast_valid;
  logic [63:0]      bcast_value;
  e_functional_unit bcast_rs;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  cdb_arbiter #(
    .DATA_WIDTH (64),
    .NUM_SRC    (6)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .res_valid_i   (res_valid),
    .res_value_i   (res_value),
    .res_ready_o   (res_ready),
    .bcast_valid_o (bcast_valid),
    .bcast_value_o (bcast_value),
    .bcast_rs_o    (bcast_rs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    res_valid = '0;
    for (int i = 0; i < 6; i++) res_value[i] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic expect_bcast(input string tag, input logic [63:0] value, input int rs);
    check({tag, "_valid"}, 64'(bcast_valid), 64'd1);
    check({tag, "_value"}, bcast_value, value);
    check({tag, "_rs"}, 64'(bcast_rs), 64'(rs));
  endtask

  initial begin
    clear_inputs();
    do_reset();
    #1;
    check("rst_valid", 64'(bcast_valid), 64'd0);
    check("rst_value", bcast_value, 64'd0);
    check("rst_rs", 64'(bcast_rs), 64'd0);
    check("rst_ready", 64'(res_ready), 64'h3f);

`ifdef CDB_ARB_BYPASS_EN
    // Bypass: a lone request is broadcast on its accepting edge and not kept.
    res_valid[5] = 1'b1;
    res_value[5] = 64'd7;
    step();
    expect_bcast("byp", 64'd7, 5);
    clear_inputs();
    step();
    check("byp_gone", 64'(bcast_valid), 64'd0);
    step();
    check("byp_gone2", 64'(bcast_valid), 64'd0);
`else
    // 1. single result: accept edge N, broadcast after N+1, pulse ends at N+2.
    res_valid[2] = 1'b1;
    res_value[2] = 64'hDEAD;
    step();
    clear_inputs();
    check("t1_lat_valid", 64'(bcast_valid), 64'd0);
    check("t1_ready", 64'(res_ready), 64'h3f);
    step();
    expect_bcast("t1", 64'hDEAD, 2);
    step();
    check("t1_pulse_end", 64'(bcast_valid), 64'd0);
    check("t1_hold_value", bcast_value, 64'hDEAD);
    check("t1_hold_rs", 64'(bcast_rs), 64'd2);

    // 2. all six at once from ptr 0: rs 0..5, values 10..15, back-to-back.
    do_reset();
    #1;
    res_valid = 6'h3f;
    for (int i = 0; i < 6; i++) res_value[i] = 64'(10 + i);
    step();
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      step();
      expect_bcast($sformatf("t2_%0d", i), 64'(10 + i), i);
    end
    step();
    check("t2_idle", 64'(bcast_valid), 64'd0);

    // 3. source 0 streams, source 3 once; ptr is back at 0 after test 2.
    res_valid[0] = 1'b1;
    res_value[0] = 64'd100;
    res_valid[3] = 1'b1;
    res_value[3] = 64'd300;
    step();
    res_valid[3] = 1'b0;
    res_value[0] = 64'd101;
    check("t3_ready0_a", 64'(res_ready[0]), 64'd1);
    step();
    expect_bcast("t3_g0", 64'd100, 0);
    check("t3_ready0_b", 64'(res_ready[0]), 64'd0);
    res_value[0] = 64'd102;
    step();
    expect_bcast("t3_g1", 64'd300, 3);
    check("t3_ready0_c", 64'(res_ready[0]), 64'd1);
    step();
    expect_bcast("t3_g2", 64'd101, 0);
    res_value[0] = 64'd103;
    step();
    expect_bcast("t3_g3", 64'd102, 0);
    res_valid[0] = 1'b0;
    step();
    expect_bcast("t3_g4", 64'd103, 0);
    step();
    check("t3_idle", 64'(bcast_valid), 64'd0);

    // 4. source 1 streams 1..4 with no bubble.
    do_reset();
    #1;
    for (int k = 1; k <= 4; k++) begin
      res_valid[1] = 1'b1;
      res_value[1] = 64'(k);
      step();
      if (k > 1) expect_bcast($sformatf("t4_%0d", k - 1), 64'(k - 1), 1);
      check($sformatf("t4_ready_%0d", k), 64'(res_ready[1]), 64'd1);
    end
    clear_inputs();
    step();
    expect_bcast("t4_4", 64'd4, 1);
    step();
    check("t4_idle", 64'(bcast_valid), 64'd0);

    // 5. reset mid-cycle with slots 0 and 4 loaded and a broadcast on the bus.
    do_reset();
    #1;
    res_valid[0] = 1'b1;
    res_value[0] = 64'h55;
    res_valid[4] = 1'b1;
    res_value[4] = 64'h44;
    step();
    clear_inputs();
    step();
    expect_bcast("t5_pre", 64'h55, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 64'(bcast_valid), 64'd0);
    check("t5_async_value", bcast_value, 64'd0);
    check("t5_async_ready", 64'(res_ready), 64'h3f);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t5_post_valid_%0d", i), 64'(bcast_valid), 64'd0);
      check($sformatf("t5_post_ready_%0d", i), 64'(res_ready), 64'h3f);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
